// File: rtl/door_sequencer.sv
// Door-cycle state machine for one elevator car: open, dwell, close, reopen on obstruction, reopen limit.
// Optional macro NUDGE_EN: the reopen limit leads to a half-speed nudge close instead of a latched fault.
module door_sequencer #(
  parameter int OPEN_CYCLES  = 3,
  parameter int CLOSE_CYCLES = 3,
  parameter int MAX_REOPEN   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arrive,
  input  logic       stopped,
  input  logic       open_btn,
  input  logic       close_btn,
  input  logic       obstruct,
  input  logic       wait_complete,
  output logic       door_open,
  output logic       door_close,
  output logic       door_wait,
  output logic       door_closed,
  output logic       cycle_done,
  output logic       nudge,
  output logic       fault,
  output logic [2:0] state
);

  // Timer must hold the longest motion phase: opening or the half-speed nudge close.
  localparam int T_MAX = (OPEN_CYCLES > 2 * CLOSE_CYCLES) ? OPEN_CYCLES : 2 * CLOSE_CYCLES;
  localparam int TW    = $clog2(T_MAX + 1);
  localparam int RW    = $clog2(MAX_REOPEN + 1);

  localparam logic [TW-1:0] OPEN_LAST  = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] CLOSE_LAST = TW'(CLOSE_CYCLES - 1);
`ifdef NUDGE_EN
  localparam logic [TW-1:0] NUDGE_LAST = TW'(2 * CLOSE_CYCLES - 1);
`endif
  localparam logic [RW-1:0] REOPEN_MAX = RW'(MAX_REOPEN);

  typedef enum logic [2:0] {
    CLOSED  = 3'd0,
    OPENING = 3'd1,
    DWELL   = 3'd2,
    CLOSING = 3'd3,
    FAULT   = 3'd4,
    NUDGE   = 3'd5
  } state_t;

  state_t          state_r;
  state_t          state_nxt;
  logic [TW-1:0]   timer;
  logic [RW-1:0]   reopen_cnt;
  logic            reopen_inc;
  logic            motion;
  logic            reopen_limit;

  function automatic logic [RW-1:0] sat_inc(input logic [RW-1:0] v);
    return (v >= REOPEN_MAX) ? v : v + 1'b1;
  endfunction

  assign motion       = (state_r == OPENING) || (state_r == CLOSING) || (state_r == NUDGE);
  assign reopen_limit = (reopen_cnt >= REOPEN_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= CLOSED;
      timer      <= '0;
      reopen_cnt <= '0;
      cycle_done <= 1'b0;
    end else begin
      state_r <= state_nxt;
      if (state_nxt != state_r)
        timer <= '0;
      else if (motion)
        timer <= timer + 1'b1;
      if ((state_nxt == CLOSED) && (state_r != CLOSED))
        reopen_cnt <= '0;
      else if (reopen_inc)
        reopen_cnt <= sat_inc(reopen_cnt);
      cycle_done <= (state_nxt == CLOSED) && (state_r != CLOSED);
    end
  end

  always_comb begin
    state_nxt  = state_r;
    reopen_inc = 1'b0;
    case (state_r)
      CLOSED:  if (arrive || (open_btn && stopped)) state_nxt = OPENING;
      OPENING: if (timer == OPEN_LAST) state_nxt = DWELL;
      DWELL: begin
        // A held open button or obstruction keeps the door parked, even over close requests.
        if (open_btn || obstruct)
          state_nxt = DWELL;
        else if (close_btn || wait_complete)
          state_nxt = CLOSING;
      end
      CLOSING: begin
        if (open_btn || obstruct) begin
          if (!reopen_limit) begin
            state_nxt  = OPENING;
            reopen_inc = 1'b1;
          end else begin
`ifdef NUDGE_EN
            state_nxt = NUDGE;
`else
            state_nxt = FAULT;
`endif
          end
        end else if (timer == CLOSE_LAST) begin
          state_nxt = CLOSED;
        end
      end
      FAULT:   state_nxt = FAULT;
`ifdef NUDGE_EN
      NUDGE:   if (timer == NUDGE_LAST) state_nxt = CLOSED;
`endif
      default: state_nxt = CLOSED;
    endcase
  end

  always_comb begin
    door_open   = 1'b0;
    door_close  = 1'b0;
    door_wait   = 1'b0;
    door_closed = 1'b0;
    nudge       = 1'b0;
    fault       = 1'b0;
    case (state_r)
      CLOSED:  door_closed = 1'b1;
      OPENING: door_open   = 1'b1;
      DWELL:   door_wait   = ~open_btn & ~obstruct;
      CLOSING: door_close  = 1'b1;
      FAULT:   fault       = 1'b1;
`ifdef NUDGE_EN
      NUDGE: begin
        door_close = 1'b1;
        nudge      = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign state = state_r;

endmodule
